// File: rtl/exu_dp_if.sv
// EXU datapath-control interface: ALU request/completion handshake plus GPR read ports.
// The master is the instruction-handler side, the slave is exu_dp_unit.
interface exu_dp_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4
);
  logic                req_vld;
  logic                req_rdy;
  logic [ALU_OP_W-1:0] alu_opcode;
  logic [XLEN-1:0]     alu_src1;
  logic [XLEN-1:0]     alu_src2;
  logic [XLEN-1:0]     alu_dst;
  logic                gpr_wen;
  logic [4:0]          gpr_waddr;
  logic                done;
  logic [4:0]          rs1_addr;
  logic [XLEN-1:0]     rs1_data;
  logic [4:0]          rs2_addr;
  logic [XLEN-1:0]     rs2_data;

  modport master (
    output req_vld, alu_opcode, alu_src1, alu_src2, gpr_wen, gpr_waddr, rs1_addr, rs2_addr,
    input  req_rdy, alu_dst, done, rs1_data, rs2_data
  );

  modport slave (
    input  req_vld, alu_opcode, alu_src1, alu_src2, gpr_wen, gpr_waddr, rs1_addr, rs2_addr,
    output req_rdy, alu_dst, done, rs1_data, rs2_data
  );
endinterface

// File: rtl/exu_dp_unit.sv
// EXU datapath: single-cycle ALU, iterative 1-bit/cycle shifter, 32-entry GPR file and writeback.
// Define EXU_DP_BYPASS_EN to forward same-cycle GPR write data onto the read ports.
module exu_dp_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned GPR_NUM  = 32,
  parameter int unsigned ALU_OP_W = 4
) (
  input logic    clk,
  input logic    rst,
  exu_dp_if.slave dp
);

  localparam logic [ALU_OP_W-1:0] OpAdd  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OpSub  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OpSll  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OpSlt  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OpSltu = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OpXor  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OpSrl  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OpSra  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] OpOr   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] OpAnd  = ALU_OP_W'(9);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     acc_q, acc_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] op_q;
  logic                wen_q;
  logic [4:0]          waddr_q;
  logic [XLEN-1:0]     alu_dst_q;
  logic                done_q;
  logic [XLEN-1:0]     gpr_q [GPR_NUM];

  logic            accept, is_shift;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res, acc_shift;
  logic            cmpl, wr_en, wr_fire;
  logic [XLEN-1:0] cmpl_data;
  logic [4:0]      wr_addr;

  assign accept   = dp.req_vld & dp.req_rdy;
  assign shamt    = dp.alu_src2[4:0];
  assign is_shift = (dp.alu_opcode == OpSll) || (dp.alu_opcode == OpSrl) ||
                    (dp.alu_opcode == OpSra);

  // Shift opcodes only reach this path with a zero shift amount, so they pass src1 through.
  always_comb begin
    alu_res = '0;
    case (dp.alu_opcode)
      OpAdd:  alu_res = dp.alu_src1 + dp.alu_src2;
      OpSub:  alu_res = dp.alu_src1 - dp.alu_src2;
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(dp.alu_src1) < $signed(dp.alu_src2)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, dp.alu_src1 < dp.alu_src2};
      OpXor:  alu_res = dp.alu_src1 ^ dp.alu_src2;
      OpOr:   alu_res = dp.alu_src1 | dp.alu_src2;
      OpAnd:  alu_res = dp.alu_src1 & dp.alu_src2;
      OpSll, OpSrl, OpSra: alu_res = dp.alu_src1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OpSll:   acc_shift = {acc_q[XLEN-2:0], 1'b0};
      OpSrl:   acc_shift = {1'b0, acc_q[XLEN-1:1]};
      default: acc_shift = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && is_shift && (shamt != 5'd0)) state_d = StShift;
      StShift: if (cnt_q == 5'd1) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    dp.req_rdy = (state_q == StIdle);
  end

  // Completion fires on the accept edge for single-cycle ops, on the last shift step otherwise.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cmpl      = 1'b0;
    cmpl_data = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    if (state_q == StIdle) begin
      if (accept) begin
        acc_d = dp.alu_src1;
        cnt_d = shamt;
        if (!is_shift || (shamt == 5'd0)) begin
          cmpl      = 1'b1;
          cmpl_data = alu_res;
          wr_en     = dp.gpr_wen;
          wr_addr   = dp.gpr_waddr;
        end
      end
    end else begin
      acc_d = acc_shift;
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        cmpl      = 1'b1;
        cmpl_data = acc_shift;
        wr_en     = wen_q;
        wr_addr   = waddr_q;
      end
    end
  end

  assign wr_fire = wr_en & ~rst & (wr_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      alu_dst_q <= '0;
      done_q    <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= cmpl;
      if (cmpl) alu_dst_q <= cmpl_data;
      if (accept) begin
        op_q    <= dp.alu_opcode;
        wen_q   <= dp.gpr_wen;
        waddr_q <= dp.gpr_waddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GPR_NUM; i++) gpr_q[i] <= '0;
    end else if (wr_fire) begin
      gpr_q[wr_addr] <= cmpl_data;
    end
  end

  always_comb begin
    dp.rs1_data = (dp.rs1_addr == 5'd0) ? '0 : gpr_q[dp.rs1_addr];
    dp.rs2_data = (dp.rs2_addr == 5'd0) ? '0 : gpr_q[dp.rs2_addr];
`ifdef EXU_DP_BYPASS_EN
    if (wr_fire && (wr_addr == dp.rs1_addr)) dp.rs1_data = cmpl_data;
    if (wr_fire && (wr_addr == dp.rs2_addr)) dp.rs2_data = cmpl_data;
`endif
  end

  assign dp.alu_dst = alu_dst_q;
  assign dp.done    = done_q;

endmodule

// File: tb/tb_exu_dp_unit.sv
// Self-checking bench for exu_dp_unit: scoreboard of expected ALU results popped on done.
// Bypass expectations follow EXU_DP_BYPASS_EN.
module tb_exu_dp_unit;

  localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpSll = 4'd2, OpSlt = 4'd3, OpSltu = 4'd4;
  localparam logic [3:0] OpXor = 4'd5, OpSrl = 4'd6, OpSra = 4'd7, OpOr = 4'd8, OpAnd = 4'd9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  exu_dp_if #(.XLEN(32), .ALU_OP_W(4)) dp ();

  exu_dp_unit #(.XLEN(32), .GPR_NUM(32), .ALU_OP_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp)
  );

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      OpAdd:  return a + b;
      OpSub:  return a - b;
      OpSll:  return a << b[4:0];
      OpSlt:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OpSltu: return (a < b) ? 32'd1 : 32'd0;
      OpXor:  return a ^ b;
      OpSrl:  return a >> b[4:0];
      OpSra:  return $unsigned($signed(a) >>> b[4:0]);
      OpOr:   return a | b;
      OpAnd:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one request; returns just after the accepting edge with req_vld dropped.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wen, input logic [4:0] wa, input bit push);
    dp.alu_opcode = op;
    dp.alu_src1   = a;
    dp.alu_src2   = b;
    dp.gpr_wen    = wen;
    dp.gpr_waddr  = wa;
    dp.req_vld    = 1'b1;
    if (push) exp_q.push_back(model_alu(op, a, b));
    @(posedge clk);
    #1;
    dp.req_vld = 1'b0;
    dp.gpr_wen = 1'b0;
  endtask

  // Cycles from acceptance to done, or -1 if the budget runs out.
  task automatic wait_done(input int limit, output int cyc);
    bit got = 1'b0;
    int n   = 0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      if (dp.done) got = 1'b1;
    end
    cyc = got ? n : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (dp.req_rdy !== 1'b1) begin
      failed++; $display("FAIL reset_rdy: got %b want 1", dp.req_rdy);
    end
    tests++;
    if (dp.done !== 1'b0) begin
      failed++; $display("FAIL reset_done: got %b want 0", dp.done);
    end
    tests++;
    if (dp.alu_dst !== 32'd0) begin
      failed++; $display("FAIL reset_dst: got %h want 0", dp.alu_dst);
    end
    dp.rs1_addr = 5'd5;
    dp.rs2_addr = 5'd31;
    #1;
    tests++;
    if (dp.rs1_data !== 32'd0 || dp.rs2_data !== 32'd0) begin
      failed++; $display("FAIL reset_gpr: got %h/%h want 0/0", dp.rs1_data, dp.rs2_data);
    end
  endtask

  task automatic test_add_wb();
    int cyc;
    logic [31:0] e;
    issue(OpAdd, 32'h0000_1000, 32'h0000_0234, 1'b1, 5'd5, 1'b1);
    wait_done(10, cyc);
    e = exp_q.pop_front();
    tests++;
    if (cyc != 1) begin failed++; $display("FAIL add_latency: got %0d want 1", cyc); end
    tests++;
    if (dp.alu_dst !== e) begin failed++; $display("FAIL add_dst: got %h want %h", dp.alu_dst, e); end
    dp.rs1_addr = 5'd5;
    @(negedge clk);
    tests++;
    if (dp.rs1_data !== 32'h0000_1234) begin
      failed++; $display("FAIL add_x5: got %h want 00001234", dp.rs1_data);
    end
    tests++;
    if (dp.done !== 1'b0 || dp.alu_dst !== 32'h0000_1234) begin
      failed++; $display("FAIL add_hold: done %b dst %h want 0/00001234", dp.done, dp.alu_dst);
    end
  endtask

  task automatic test_sra_stall();
    int cyc = 0, stall = 0;
    bit got = 1'b0;
    logic [31:0] e;
    issue(OpSra, 32'h8000_0000, 32'd4, 1'b0, 5'd0, 1'b1);
    // Competing request held through the stall must not be taken.
    dp.alu_opcode = OpAdd; dp.alu_src1 = 32'd7; dp.alu_src2 = 32'd9;
    dp.gpr_wen = 1'b1; dp.gpr_waddr = 5'd9; dp.req_vld = 1'b1;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dp.done) got = 1'b1;
      else if (!dp.req_rdy) stall++;
    end
    dp.req_vld = 1'b0;
    dp.gpr_wen = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (cyc != 5 || !got) begin failed++; $display("FAIL sra_latency: got %0d want 5", cyc); end
    tests++;
    if (stall != 4) begin failed++; $display("FAIL sra_stall: got %0d want 4", stall); end
    tests++;
    if (dp.alu_dst !== e || e !== 32'hF800_0000) begin
      failed++; $display("FAIL sra_dst: got %h want f8000000", dp.alu_dst);
    end
    dp.rs2_addr = 5'd9;
    @(negedge clk);
    tests++;
    if (dp.done !== 1'b0 || dp.rs2_data !== 32'd0) begin
      failed++; $display("FAIL sra_no_accept: done %b x9 %h want 0/0", dp.done, dp.rs2_data);
    end
  endtask

  task automatic test_shift_lat();
    logic [3:0]  op [3] = '{OpSll, OpSll, OpSrl};
    logic [31:0] a  [3] = '{32'h1, 32'hA5A5_0001, 32'hF000_000F};
    logic [31:0] b  [3] = '{32'd31, 32'd0, 32'h25};
    int          lt [3] = '{32, 1, 6};
    int cyc;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      issue(op[i], a[i], b[i], 1'b1, 5'd12, 1'b1);
      wait_done(40, cyc);
      e = exp_q.pop_front();
      tests++;
      if (cyc != lt[i]) begin
        failed++; $display("FAIL shift_latency[%0d]: got %0d want %0d", i, cyc, lt[i]);
      end
      tests++;
      if (dp.alu_dst !== e) begin
        failed++; $display("FAIL shift_dst[%0d]: got %h want %h", i, dp.alu_dst, e);
      end
      dp.rs1_addr = 5'd12;
      #1;
      tests++;
      if (dp.rs1_data !== e) begin
        failed++; $display("FAIL shift_wb[%0d]: got %h want %h", i, dp.rs1_data, e);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  op [9] = '{OpAdd, OpSlt, OpSltu, OpSlt, OpSub, OpXor, OpOr, OpAnd, 4'd12};
    logic [31:0] a  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd5,
                            32'hF0F0_1234, 32'h0F00_0001, 32'hFFFF_00FF, 32'd5};
    logic [31:0] b  [9] = '{32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd7,
                            32'h0FF0_00FF, 32'h00F0_0010, 32'h1234_5678, 32'd3};
    logic [4:0]  wa [9] = '{5'd0, 5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 5'd10};
    int cyc;
    logic [31:0] e;
    for (int i = 0; i < 9; i++) begin
      issue(op[i], a[i], b[i], 1'b1, wa[i], 1'b1);
      wait_done(10, cyc);
      e = exp_q.pop_front();
      tests++;
      if (cyc != 1 || dp.alu_dst !== e) begin
        failed++; $display("FAIL alu[%0d]: got %h lat %0d want %h lat 1", i, dp.alu_dst, cyc, e);
      end
      dp.rs1_addr = wa[i];
      #1;
      tests++;
      if (dp.rs1_data !== ((wa[i] == 5'd0) ? 32'd0 : e)) begin
        failed++; $display("FAIL alu_wb[%0d]: got %h want %h", i, dp.rs1_data, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op [4] = '{OpAdd, OpSub, OpOr, OpXor};
    logic [31:0] a  [4] = '{32'd100, 32'd3, 32'hAA00_0000, 32'hFFFF_0000};
    logic [31:0] b  [4] = '{32'd23, 32'd5, 32'h0000_0055, 32'h00FF_FF00};
    int cyc;
    logic [31:0] e;
    issue(op[0], a[0], b[0], 1'b1, 5'd20, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_done(10, cyc);
      e = exp_q.pop_front();
      tests++;
      if (cyc != 1 || dp.alu_dst !== e) begin
        failed++; $display("FAIL b2b[%0d]: got %h lat %0d want %h lat 1", i, dp.alu_dst, cyc, e);
      end
      if (i < 3) issue(op[i+1], a[i+1], b[i+1], 1'b1, 5'd20 + 5'(i + 1), 1'b1);
    end
    dp.rs2_addr = 5'd22;
    #1;
    tests++;
    if (dp.rs2_data !== 32'hAA00_0055) begin
      failed++; $display("FAIL b2b_wb: got %h want aa000055", dp.rs2_data);
    end
  endtask

  task automatic test_bypass();
    int cyc;
    logic [31:0] e, want;
    issue(OpAdd, 32'h11, 32'h0, 1'b1, 5'd3, 1'b1);
    wait_done(10, cyc);
    void'(exp_q.pop_front());
    dp.rs2_addr = 5'd3;
    @(negedge clk);
    dp.alu_opcode = OpAdd; dp.alu_src1 = 32'hDEAD_0000; dp.alu_src2 = 32'h0000_BEEF;
    dp.gpr_wen = 1'b1; dp.gpr_waddr = 5'd3; dp.req_vld = 1'b1;
    exp_q.push_back(model_alu(OpAdd, 32'hDEAD_0000, 32'h0000_BEEF));
    #1;
`ifdef EXU_DP_BYPASS_EN
    want = 32'hDEAD_BEEF;
`else
    want = 32'h0000_0011;
`endif
    tests++;
    if (dp.rs2_data !== want) begin
      failed++; $display("FAIL bypass_same_cycle: got %h want %h", dp.rs2_data, want);
    end
    @(posedge clk);
    #1;
    dp.req_vld = 1'b0;
    dp.gpr_wen = 1'b0;
    wait_done(10, cyc);
    e = exp_q.pop_front();
    tests++;
    if (dp.alu_dst !== e || dp.rs2_data !== 32'hDEAD_BEEF) begin
      failed++; $display("FAIL bypass_next: dst %h x3 %h want %h", dp.alu_dst, dp.rs2_data, e);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit seen = 1'b0;
    issue(OpSrl, 32'hFFFF_FFFF, 32'd20, 1'b1, 5'd7, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (dp.req_rdy !== 1'b1 || dp.done !== 1'b0 || dp.alu_dst !== 32'd0) begin
      failed++;
      $display("FAIL rst_mid: rdy %b done %b dst %h want 1/0/0", dp.req_rdy, dp.done, dp.alu_dst);
    end
    repeat (25) begin
      @(negedge clk);
      if (dp.done) seen = 1'b1;
    end
    tests++;
    if (seen) begin failed++; $display("FAIL rst_mid_done: got done pulse want none"); end
    dp.rs1_addr = 5'd7;
    dp.rs2_addr = 5'd5;
    #1;
    tests++;
    if (dp.rs1_data !== 32'd0 || dp.rs2_data !== 32'd0) begin
      failed++; $display("FAIL rst_mid_gpr: x7 %h x5 %h want 0/0", dp.rs1_data, dp.rs2_data);
    end
  endtask

  initial begin
    dp.req_vld = 1'b0; dp.alu_opcode = '0; dp.alu_src1 = '0; dp.alu_src2 = '0;
    dp.gpr_wen = 1'b0; dp.gpr_waddr = '0; dp.rs1_addr = '0; dp.rs2_addr = '0;
    test_reset();
    test_add_wb();
    test_sra_stall();
    test_shift_lat();
    test_alu_ops();
    test_back_to_back();
    test_bypass();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exu_dp_unit.md
Name: exu_dp_unit

Overview:
- Slave end of the EXU datapath-control interface. Instruction handlers drive ALU opcode/operands and GPR write controls; this block evaluates the ALU, owns the 32-entry GPR file and commits the writeback.
- Single-cycle ops complete immediately. Shifts run iteratively, 1 bit/cycle, and stall the issuing side through a valid/ready handshake.
- Sits between the EXU instruction handlers and the GPR read ports used by decode.

Parameters:
- XLEN, 32, datapath and GPR width
- GPR_NUM, 32, GPR count; x0 reads zero
- ALU_OP_W, 4, ALU opcode width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_vld  in  1  handler presents a valid op
- req_rdy  out  1  block can accept an op
- alu_opcode  in  ALU_OP_W  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
- alu_src1  in  XLEN  operand 1
- alu_src2  in  XLEN  operand 2; shifts use bits [4:0]
- alu_dst  out  XLEN  ALU result; valid when done=1
- gpr_wen  in  1  write result to GPR
- gpr_waddr  in  5  destination register
- done  out  1  one-cycle pulse: op complete, alu_dst valid
- rs1_addr  in  5  read port 1 address
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_addr  in  5  read port 2 address
- rs2_data  out  XLEN  read port 2 data (combinational)

Behaviour:
- FSM states: IDLE and SHIFT.
- Reset:
  - state=IDLE, req_rdy=1, done=0, alu_dst=0.
  - All GPRs cleared to 0.
  - Shift counter and shift accumulator cleared.
- IDLE, req_rdy=1:
  - On req_vld with a non-shift opcode: result is computed and registered. Next cycle done=1 and alu_dst=result. If gpr_wen was set at acceptance, the GPR is written on that same edge. Latency 1.
  - On req_vld with SLL/SRL/SRA: capture src1 into the accumulator, shamt=src2[4:0], opcode, gpr_wen, gpr_waddr.
    - shamt==0: behaves as single-cycle, result = src1.
    - shamt!=0: go to SHIFT.
- SHIFT, req_rdy=0:
  - Each cycle shift the accumulator 1 bit and decrement the counter. SRA fills with the sign bit.
  - Counter reaching 0 returns to IDLE and the next cycle pulses done.
  - Latency = shamt+1 cycles; shamt=31 gives 32 cycles.
- Operands and opcode are sampled only on acceptance. Input changes during SHIFT are ignored.
- ALU semantics:
  - ADD/SUB: mod 2^XLEN, overflow discarded.
  - SLT: signed compare; SLTU: unsigned compare; both return 0/1 zero-extended.
  - Unlisted opcode values produce 0 but still complete and write back.
- GPR writes to waddr 0 are dropped; rs*_data for address 0 is always 0.
- alu_dst holds its value until the next completion.
- Back-to-back: a new op may be accepted in the same cycle done is pulsed (IDLE, req_rdy=1).
- rst asserted mid-SHIFT: abort the op, no writeback, no done, return to the reset state next cycle.

Optional Feature:
- Macro EXU_DP_BYPASS_EN.
- Defined: a read port whose address equals the GPR address being written this cycle (nonzero, write enabled) returns the new write data combinationally.
- Undefined: reads return the pre-write register value, and the new value is visible from the next cycle.

Test Plan:
- Reset, then ADD src1=0x0000_1000, src2=0x0000_0234, gpr_wen=1, waddr=5 -> done the next cycle, alu_dst=0x0000_1234; the cycle after, rs1_addr=5 gives 0x0000_1234.
- SRA src1=0x8000_0000, src2=4 -> req_rdy low for 4 cycles, done on cycle 5, alu_dst=0xF800_0000. req_vld held during the stall is not accepted.
- SLL src1=1, src2=31 -> done after 32 cycles, alu_dst=0x8000_0000. SLL with src2=0 -> 1-cycle latency, alu_dst=src1.
- ADD 0xFFFF_FFFF+1 with waddr=0 -> alu_dst=0, x0 still reads 0. SLT 0xFFFF_FFFF vs 1 -> 1; SLTU on the same operands -> 0.
- rst pulsed during SRL shamt=20 with gpr_wen=1, waddr=7 -> no done, x7 stays 0, req_rdy=1 the cycle after reset.
- Same-cycle write x3=0xDEAD_BEEF and read rs2_addr=3 -> 0xDEAD_BEEF with EXU_DP_BYPASS_EN, old value without it.
